// File: rtl/uart_bus_arbiter.sv
// Shares the UART bus slave between the 68k bus (m0) and the boot/debug monitor (m1).
// Round-robin grant, one strobe cycle per attempt, TX-busy hold-off, grant-to-response timeout.
module uart_bus_arbiter #(
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic [7:0]  m0_addr,
   input  logic [15:0] m0_data_write,
   input  logic        m0_uds,
   input  logic        m0_lds,
   input  logic        m0_rw,
   output logic [15:0] m0_data_read,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [7:0]  m1_addr,
   input  logic [15:0] m1_data_write,
   input  logic        m1_uds,
   input  logic        m1_lds,
   input  logic        m1_rw,
   output logic [15:0] m1_data_read,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [7:0]  u_addr,
   output logic [15:0] u_data_write,
   output logic        u_uds,
   output logic        u_lds,
   output logic        u_rw,
   input  logic [15:0] u_data_read,
   input  logic        u_ack,
   input  logic        u_tx_active,
   output logic [2:0]  dbg_state
);
   // Handshake: a master holds req (and its fields) until it sees a one-cycle ack or err,
   // and drops req by the following edge; exactly one of ack/err ends each granted request.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HOLD  = 3'd1,
      S_ISSUE = 3'd2,
      S_CHECK = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_d;
   logic        grant, grant_d;
   logic        last_grant, last_grant_d;
   logic [15:0] timer, timer_d;
   logic        sh_uds, sh_lds;
   logic        uds_d, lds_d, rw_d;
   logic [7:0]  addr_d;
   logic [15:0] wdata_d, rdata_d;
   logic        ack_d, err_d;
   logic        pick, sel_uds, sel_lds, sel_rw;
   logic [7:0]  sel_addr;
   logic [15:0] sel_data;
   logic        timed_out;

   assign pick      = (m0_req & m1_req) ? ~last_grant : m1_req;
   assign sel_addr  = pick ? m1_addr : m0_addr;
   assign sel_data  = pick ? m1_data_write : m0_data_write;
   assign sel_uds   = pick ? m1_uds : m0_uds;
   assign sel_lds   = pick ? m1_lds : m0_lds;
   assign sel_rw    = pick ? m1_rw : m0_rw;
   // Compare with >= so a limit that lands on an ISSUE cycle still expires at the next CHECK.
   assign timed_out = (timer >= TIMER_LAST);
   assign dbg_state = state;

   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      timer_d      = timer;
      addr_d       = u_addr;
      wdata_d      = u_data_write;
      rw_d         = u_rw;
      uds_d        = sh_uds;
      lds_d        = sh_lds;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      rdata_d      = 16'h0000;
      case (state)
         S_IDLE: begin
            if (m0_req | m1_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               timer_d      = 16'd0;
               addr_d       = sel_addr;
               wdata_d      = sel_data;
               rw_d         = sel_rw;
               uds_d        = sel_uds;
               lds_d        = sel_lds;
               if ((!sel_uds && !sel_lds) || (sel_addr[7:1] != 7'd0)) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            timer_d = timer + 16'd1;
            if (timed_out) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else if (!(!u_rw && sh_uds && u_tx_active)) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = timer + 16'd1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            timer_d = timer + 16'd1;
            if (u_ack) begin
               state_d = S_RESP;
               ack_d   = 1'b1;
               rdata_d = u_data_read & {{8{sh_uds}}, {8{sh_lds}}};
            end else if (timed_out) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
         timer        <= 16'd0;
         sh_uds       <= 1'b0;
         sh_lds       <= 1'b0;
         u_addr       <= 8'h00;
         u_data_write <= 16'h0000;
         u_rw         <= 1'b1;
         u_uds        <= 1'b0;
         u_lds        <= 1'b0;
         m0_ack       <= 1'b0;
         m0_err       <= 1'b0;
         m0_data_read <= 16'h0000;
         m1_ack       <= 1'b0;
         m1_err       <= 1'b0;
         m1_data_read <= 16'h0000;
      end else begin
         state        <= state_d;
         grant        <= grant_d;
         last_grant   <= last_grant_d;
         timer        <= timer_d;
         sh_uds       <= uds_d;
         sh_lds       <= lds_d;
         u_addr       <= addr_d;
         u_data_write <= wdata_d;
         u_rw         <= rw_d;
         u_uds        <= (state_d == S_ISSUE) & uds_d;
         u_lds        <= (state_d == S_ISSUE) & lds_d;
         m0_ack       <= ack_d & ~grant_d;
         m0_err       <= err_d & ~grant_d;
         m0_data_read <= (ack_d & ~grant_d) ? rdata_d : 16'h0000;
         m1_ack       <= ack_d & grant_d;
         m1_err       <= err_d & grant_d;
         m1_data_read <= (ack_d & grant_d) ? rdata_d : 16'h0000;
      end
   end
endmodule
